// File: rtl/vend_sequencer.sv
// vend_sequencer
//   Transaction controller for the coin-operated vending datapath. It
//   accumulates 1/5/10 lei coins into a credit register. A purchase request
//   drives the product dispenser over a req/ack handshake. Any remaining
//   credit is then paid back one coin at a time, largest coin first, through
//   the coin ejector (req/ack).
//
// Ports
//   clk          system clock, rising-edge
//   reset        asynchronous, active-high reset
//   coin1/5/10   one-cycle pulses from the coin-slot sensors
//   sel          one-cycle purchase request
//   refund       one-cycle request to return all credit
//   vend_req     dispense one product, held until vend_ack
//   vend_ack     dispenser done (looked at only in VEND)
//   pay_req      eject the coin given by pay_coin, held until pay_ack
//   pay_coin     00 none, 01 = 1 leu, 10 = 5 lei, 11 = 10 lei
//   pay_ack      ejector done (looked at only in PAY)
//   credit       current credit in lei (registered)
//   coin_reject  one-cycle pulse: last inserted coin(s) returned, not credited
//   busy         controller is not in IDLE
module vend_sequencer #(
    parameter int PRICE      = 3,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin1,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                sel,
    input  logic                refund,
    output logic                vend_req,
    input  logic                vend_ack,
    output logic                pay_req,
    output logic [1:0]          pay_coin,
    input  logic                pay_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                busy
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_VEND   = 2'b01;
    localparam logic [1:0] S_CHANGE = 2'b10;
    localparam logic [1:0] S_PAY    = 2'b11;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_1    = 2'b01;
    localparam logic [1:0] C_5    = 2'b10;
    localparam logic [1:0] C_10   = 2'b11;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            C_1:     return CREDIT_W'(1);
            C_5:     return CREDIT_W'(5);
            C_10:    return CREDIT_W'(10);
            default: return '0;
        endcase
    endfunction

    logic [1:0]          state;
    logic [1:0]          in_coin;
    logic                any_coin;
    logic                multi_coin;
    logic [CREDIT_W:0]   sum;
    logic                fits;
    logic [1:0]          change_coin;

    assign busy = (state != S_IDLE);

    // Decode the coin slot. Two or more simultaneous pulses cannot be told
    // apart reliably, so they are all rejected together.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_coin    = C_NONE;
        any_coin   = coin1 | coin5 | coin10;
        multi_coin = (coin1 & coin5) | (coin1 & coin10) | (coin5 & coin10);
        if (coin10)     in_coin = C_10;
        else if (coin5) in_coin = C_5;
        else if (coin1) in_coin = C_1;
        // One extra bit keeps the sum from wrapping before the limit check.
        sum  = {1'b0, credit} + {1'b0, coin_value(in_coin)};
        fits = (sum <= MAX_C);
    end

    // Greedy change: the largest coin that does not exceed the credit.
    always_comb begin
        change_coin = C_NONE;
        if (credit >= CREDIT_W'(10))     change_coin = C_10;
        else if (credit >= CREDIT_W'(5)) change_coin = C_5;
        else if (credit != '0)           change_coin = C_1;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            credit      <= '0;
            vend_req    <= 1'b0;
            pay_req     <= 1'b0;
            pay_coin    <= C_NONE;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (refund) begin
                        state       <= S_CHANGE;
                        coin_reject <= any_coin;
                    end else if (sel && credit >= PRICE_C) begin
                        credit      <= credit - PRICE_C;
                        vend_req    <= 1'b1;
                        state       <= S_VEND;
                        coin_reject <= any_coin;
                    end else if (multi_coin) begin
                        coin_reject <= 1'b1;
                    end else if (any_coin) begin
                        if (fits) credit      <= sum[CREDIT_W-1:0];
                        else      coin_reject <= 1'b1;
                    end
                end
                S_VEND: begin
                    coin_reject <= any_coin;
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        state    <= (credit != '0) ? S_CHANGE : S_IDLE;
                    end
                end
                S_CHANGE: begin
                    coin_reject <= any_coin;
                    if (credit == '0) begin
                        pay_coin <= C_NONE;
                        state    <= S_IDLE;
                    end else begin
                        pay_coin <= change_coin;
                        pay_req  <= 1'b1;
                        state    <= S_PAY;
                    end
                end
                default: begin // S_PAY
                    coin_reject <= any_coin;
                    if (pay_ack) begin
                        credit   <= credit - coin_value(pay_coin);
                        pay_req  <= 1'b0;
                        pay_coin <= C_NONE;
                        state    <= S_CHANGE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin1, coin5, coin10, sel, refund;
    logic       vend_ack, pay_ack;
    logic       vend_req, pay_req, coin_reject, busy;
    logic [1:0] pay_coin;
    logic [5:0] credit;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected ejected coin and expected credit after its ack.
    logic [1:0] exp_coin_q[$];
    logic [5:0] exp_credit_q[$];

    always #5 clk = ~clk;

    vend_sequencer #(.PRICE(3), .CREDIT_W(6), .MAX_CREDIT(50)) dut (
        .clk(clk), .reset(reset),
        .coin1(coin1), .coin5(coin5), .coin10(coin10),
        .sel(sel), .refund(refund),
        .vend_req(vend_req), .vend_ack(vend_ack),
        .pay_req(pay_req), .pay_coin(pay_coin), .pay_ack(pay_ack),
        .credit(credit), .coin_reject(coin_reject), .busy(busy)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Insert one coin: 1, 5 or 10.
    task automatic insert(input int value);
        coin1  = (value == 1);
        coin5  = (value == 5);
        coin10 = (value == 10);
        step();
        coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0;
    endtask

    task automatic expect_pay(input logic [1:0] c, input logic [5:0] cr);
        exp_coin_q.push_back(c);
        exp_credit_q.push_back(cr);
    endtask

    // Act as the coin ejector: serve every queued payment and compare.
    task automatic serve_pay();
        logic [1:0] exp_c;
        logic [5:0] exp_cr;
        int         wait_cnt;
        while (exp_coin_q.size() > 0) begin
            exp_c  = exp_coin_q.pop_front();
            exp_cr = exp_credit_q.pop_front();
            wait_cnt = 0;
            while (pay_req !== 1'b1 && wait_cnt < 20) begin
                step();
                wait_cnt++;
            end
            checks++;
            if (pay_req !== 1'b1) begin
                failures++;
                $display("FAIL pay_req_timeout: pay_req=%b after %0d cycles, required 1", pay_req, wait_cnt);
                exp_coin_q.delete();
                exp_credit_q.delete();
                return;
            end
            checks++;
            if (pay_coin !== exp_c) begin
                failures++;
                $display("FAIL pay_coin: got %b, required %b", pay_coin, exp_c);
            end
            // Hold off the ack a little; coin must stay stable meanwhile.
            for (int i = 0; i < $urandom_range(0, 2); i++) begin
                step();
                checks++;
                if (pay_req !== 1'b1 || pay_coin !== exp_c || vend_req !== 1'b0) begin
                    failures++;
                    $display("FAIL pay_hold: pay_req=%b pay_coin=%b vend_req=%b, required 1 %b 0",
                             pay_req, pay_coin, vend_req, exp_c);
                end
            end
            pay_ack = 1'b1;
            step();
            pay_ack = 1'b0;
            checks++;
            if (pay_req !== 1'b0 || credit !== exp_cr) begin
                failures++;
                $display("FAIL pay_done: pay_req=%b credit=%0d, required 0 %0d", pay_req, credit, exp_cr);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (vend_req !== 0 || pay_req !== 0 || pay_coin !== 0 || credit !== 0 ||
            coin_reject !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL reset_state: vend=%b pay=%b coin=%b credit=%0d rej=%b busy=%b, required all 0",
                     vend_req, pay_req, pay_coin, credit, coin_reject, busy);
        end
    endtask

    task automatic test_vend_change();
        int high_cycles;
        insert(5);
        checks++;
        if (credit !== 6'd5) begin
            failures++;
            $display("FAIL vend_credit_in: got %0d, required 5", credit);
        end
        sel = 1'b1;
        step();
        sel = 1'b0;
        checks++;
        if (vend_req !== 1'b1 || credit !== 6'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL vend_start: vend_req=%b credit=%0d busy=%b, required 1 2 1", vend_req, credit, busy);
        end
        high_cycles = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (vend_req === 1'b1) high_cycles++;
        end
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        checks++;
        if (high_cycles != 4 || vend_req !== 1'b0) begin
            failures++;
            $display("FAIL vend_len: high %0d cycles, vend_req=%b after ack, required 4 and 0", high_cycles, vend_req);
        end
        expect_pay(2'b01, 6'd1);
        expect_pay(2'b01, 6'd0);
        serve_pay();
        step();
        checks++;
        if (busy !== 1'b0 || credit !== 6'd0) begin
            failures++;
            $display("FAIL vend_end: busy=%b credit=%0d, required 0 0", busy, credit);
        end
    endtask

    task automatic test_multi_coin();
        coin10 = 1'b1; coin1 = 1'b1;
        step();
        coin10 = 1'b0; coin1 = 1'b0;
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd0) begin
            failures++;
            $display("FAIL multi_coin: reject=%b credit=%0d, required 1 0", coin_reject, credit);
        end
        step();
        checks++;
        if (coin_reject !== 1'b0) begin
            failures++;
            $display("FAIL reject_pulse: reject=%b, required 0", coin_reject);
        end
    endtask

    task automatic test_limit();
        int seq[8] = '{10, 10, 10, 10, 5, 1, 1, 1};
        foreach (seq[i]) insert(seq[i]);
        checks++;
        if (credit !== 6'd48) begin
            failures++;
            $display("FAIL limit_fill: credit=%0d, required 48", credit);
        end
        insert(5);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd48) begin
            failures++;
            $display("FAIL limit_over: reject=%b credit=%0d, required 1 48", coin_reject, credit);
        end
        insert(1);
        insert(1);
        checks++;
        if (coin_reject !== 1'b0 || credit !== 6'd50) begin
            failures++;
            $display("FAIL limit_max: reject=%b credit=%0d, required 0 50", coin_reject, credit);
        end
        insert(1);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd50) begin
            failures++;
            $display("FAIL limit_at_max: reject=%b credit=%0d, required 1 50", coin_reject, credit);
        end
        refund = 1'b1;
        step();
        refund = 1'b0;
        for (int k = 4; k >= 0; k--) expect_pay(2'b11, 6'(k * 10));
        serve_pay();
        step();
    endtask

    task automatic test_refund();
        insert(10); insert(5); insert(1); insert(1);
        checks++;
        if (credit !== 6'd17) begin
            failures++;
            $display("FAIL refund_fill: credit=%0d, required 17", credit);
        end
        refund = 1'b1;
        coin1  = 1'b1;   // coin in the refund cycle is rejected
        step();
        refund = 1'b0;
        coin1  = 1'b0;
        checks++;
        if (coin_reject !== 1'b1 || busy !== 1'b1 || credit !== 6'd17) begin
            failures++;
            $display("FAIL refund_start: reject=%b busy=%b credit=%0d, required 1 1 17", coin_reject, busy, credit);
        end
        expect_pay(2'b11, 6'd7);
        expect_pay(2'b10, 6'd2);
        expect_pay(2'b01, 6'd1);
        expect_pay(2'b01, 6'd0);
        serve_pay();
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL refund_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_low_credit();
        insert(1); insert(1);
        sel = 1'b1;
        step();
        sel = 1'b0;
        checks++;
        if (vend_req !== 1'b0 || credit !== 6'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL low_sel: vend_req=%b credit=%0d busy=%b, required 0 2 0", vend_req, credit, busy);
        end
        // Stray acks in IDLE must do nothing.
        pay_ack = 1'b1; vend_ack = 1'b1;
        step();
        pay_ack = 1'b0; vend_ack = 1'b0;
        checks++;
        if (credit !== 6'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack: credit=%0d busy=%b, required 2 0", credit, busy);
        end
        insert(1);
        sel = 1'b1;
        step();
        sel = 1'b0;
        insert(1);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd0 || vend_req !== 1'b1) begin
            failures++;
            $display("FAIL vend_coin: reject=%b credit=%0d vend_req=%b, required 1 0 1", coin_reject, credit, vend_req);
        end
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || vend_req !== 1'b0 || pay_req !== 1'b0) begin
            failures++;
            $display("FAIL vend_exact: busy=%b vend_req=%b pay_req=%b, required 0 0 0", busy, vend_req, pay_req);
        end
    endtask

    task automatic test_reset_midpay();
        insert(10);
        refund = 1'b1;
        step();
        refund = 1'b0;
        step();
        checks++;
        if (pay_req !== 1'b1) begin
            failures++;
            $display("FAIL midpay_setup: pay_req=%b, required 1", pay_req);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pay_req !== 1'b0 || credit !== 6'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pay_req=%b credit=%0d busy=%b, required 0 0 0", pay_req, credit, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        insert(1);
        checks++;
        if (credit !== 6'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: credit=%0d busy=%b, required 1 0", credit, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        coin1 = 0; coin5 = 0; coin10 = 0; sel = 0; refund = 0;
        vend_ack = 0; pay_ack = 0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        test_vend_change();
        test_multi_coin();
        test_limit();
        test_refund();
        test_low_credit();
        test_reset_midpay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
